// File: rtl/neuron_bus_pkg.sv
// neuron_bus_pkg
//   Shared constants and types for the neuron peripheral bus initiator.
//   - Fixed 5-bit register map of the neuron slave (zero-extended onto the 9-bit bus).
//   - Status register bit positions.
//   - FSM state encoding used by neuron_bus_master.
package neuron_bus_pkg;

  localparam int unsigned AddrWidth = 9;

  // Neuron slave register map
  localparam logic [4:0] ADDR_COEFF0 = 5'd0;
  localparam logic [4:0] ADDR_OFFSET = 5'd20;
  localparam logic [4:0] ADDR_INDATO = 5'd21;
  localparam logic [4:0] ADDR_START  = 5'd22;
  localparam logic [4:0] ADDR_RESULT = 5'd23;
  localparam logic [4:0] ADDR_STATUS = 5'd24;

  // Status register bits
  localparam int unsigned STAT_LISTO = 0;
  localparam int unsigned STAT_ERROR = 1;

  typedef enum logic [2:0] {
    StCfgWait,
    StCfgWr,
    StIdle,
    StDataWr,
    StStartWr,
    StPoll,
    StResRd,
    StOutput
  } state_e;

  // Register-map constants are 5 bits; the bus address is wider.
  function automatic logic [AddrWidth-1:0] bus_addr(input logic [4:0] a);
    return {{(AddrWidth - 5){1'b0}}, a};
  endfunction

endpackage

// File: rtl/neuron_bus_poll_timer.sv
// neuron_bus_poll_timer
//   Counts status polls for one evaluation and flags the last allowed poll.
//   Ports:
//     i_clk   - clock
//     i_rst   - synchronous active-high reset (clears count)
//     i_clear - clear count (takes priority over increment)
//     i_incr  - count one unsuccessful poll
//     o_last  - the poll being made now is poll number Terminal
module neuron_bus_poll_timer #(
  parameter int unsigned Terminal = 1023
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_incr,
  output logic o_last
);

  localparam int unsigned CntW = $clog2(Terminal + 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_incr && (r_count != CntW'(Terminal))) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds the number of polls already made, so the current poll is the
  // final one when Terminal-1 have gone before it.
  assign o_last = (r_count == CntW'(Terminal - 1));

endmodule

// File: rtl/neuron_bus_master.sv
// neuron_bus_master
//   Bus initiator for the neuron peripheral. Loads NumCoeff coefficients plus
//   the offset from a coefficient stream, then for each input sample writes the
//   sample, writes Start, polls status, reads the result and presents it on a
//   valid/ready output stream together with an error flag.
//   Ports:
//     CLK, MasterReset             - clock, synchronous active-high reset
//     coeff_valid/ready/data       - coefficient stream (coeff 0..NumCoeff-1, then offset)
//     in_valid/ready/data          - input sample stream
//     out_valid/ready/data/error   - result stream (error = slave error bit or poll timeout)
//     cfg_done                     - full coefficient set loaded
//     write/read/address/writedata - bus strobes and address/data towards the slave
//     readdata                     - slave read data, valid in the cycle read=1
module neuron_bus_master
  import neuron_bus_pkg::*;
#(
  parameter int unsigned Width       = 32,
  parameter int unsigned NumCoeff    = 20,
  parameter int unsigned PollTimeout = 1023
) (
  input  logic                 CLK,
  input  logic                 MasterReset,
  input  logic                 coeff_valid,
  output logic                 coeff_ready,
  input  logic [Width-1:0]     coeff_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Width-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Width-1:0]     out_data,
  output logic                 out_error,
  output logic                 cfg_done,
  output logic                 write,
  output logic                 read,
  output logic [AddrWidth-1:0] address,
  output logic [Width-1:0]     writedata,
  input  logic [Width-1:0]     readdata
);

  // Index NumCoeff is the offset word, the last one of the load sequence.
  localparam logic [4:0] IdxLast = 5'(NumCoeff);

  state_e                r_state;
  logic [4:0]            r_idx;
  logic                  r_err;
  logic                  r_write;
  logic                  r_read;
  logic [AddrWidth-1:0]  r_address;
  logic [Width-1:0]      r_writedata;
  logic                  r_coeff_ready;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [Width-1:0]      r_out_data;
  logic                  r_out_error;
  logic                  r_cfg_done;

  logic                  w_poll_clear;
  logic                  w_poll_incr;
  logic                  w_poll_last;

  assign w_poll_clear = (r_state == StStartWr);
  assign w_poll_incr  = (r_state == StPoll) && !readdata[STAT_LISTO];

  neuron_bus_poll_timer #(
    .Terminal (PollTimeout)
  ) u_poll_timer (
    .i_clk   (CLK),
    .i_rst   (MasterReset),
    .i_clear (w_poll_clear),
    .i_incr  (w_poll_incr),
    .o_last  (w_poll_last)
  );

  // All outputs are registered: each transition loads the values that the
  // destination state presents on the bus / streams.
  always_ff @(posedge CLK) begin
    if (MasterReset) begin
      r_state       <= StCfgWait;
      r_idx         <= '0;
      r_err         <= 1'b0;
      r_write       <= 1'b0;
      r_read        <= 1'b0;
      r_address     <= '0;
      r_writedata   <= '0;
      r_coeff_ready <= 1'b0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_error   <= 1'b0;
      r_cfg_done    <= 1'b0;
    end else begin
      // Bus strobes are single-cycle; only the branches below re-arm them.
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_address   <= '0;
      r_writedata <= '0;

      case (r_state)
        StCfgWait: begin
          if (coeff_valid && r_coeff_ready) begin
            r_coeff_ready <= 1'b0;
            r_write       <= 1'b1;
            r_address     <= bus_addr(ADDR_COEFF0 + r_idx);
            r_writedata   <= coeff_data;
            r_state       <= StCfgWr;
          end else begin
            r_coeff_ready <= 1'b1;
          end
        end

        StCfgWr: begin
          if (r_idx == IdxLast) begin
            r_idx      <= '0;
            r_cfg_done <= 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= StIdle;
          end else begin
            r_idx         <= r_idx + 5'd1;
            r_coeff_ready <= 1'b1;
            r_state       <= StCfgWait;
          end
        end

        StIdle: begin
          // A new coefficient set wins over a pending sample.
          if (coeff_valid && r_cfg_done) begin
            r_cfg_done <= 1'b0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= StCfgWait;
          end else if (in_valid && r_in_ready) begin
            r_in_ready  <= 1'b0;
            r_write     <= 1'b1;
            r_address   <= bus_addr(ADDR_INDATO);
            r_writedata <= in_data;
            r_state     <= StDataWr;
          end else begin
            r_in_ready <= r_cfg_done;
          end
        end

        StDataWr: begin
          r_write     <= 1'b1;
          r_address   <= bus_addr(ADDR_START);
          r_writedata <= Width'(1);
          r_state     <= StStartWr;
        end

        StStartWr: begin
          r_read    <= 1'b1;
          r_address <= bus_addr(ADDR_STATUS);
          r_state   <= StPoll;
        end

        StPoll: begin
          if (readdata[STAT_LISTO]) begin
            r_err     <= readdata[STAT_ERROR];
            r_read    <= 1'b1;
            r_address <= bus_addr(ADDR_RESULT);
            r_state   <= StResRd;
          end else if (w_poll_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= '0;
            r_out_error <= 1'b1;
            r_state     <= StOutput;
          end else begin
            r_read    <= 1'b1;
            r_address <= bus_addr(ADDR_STATUS);
          end
        end

        StResRd: begin
          r_out_valid <= 1'b1;
          r_out_data  <= readdata;
          r_out_error <= r_err;
          r_state     <= StOutput;
        end

        StOutput: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_error <= 1'b0;
            r_in_ready  <= r_cfg_done;
            r_state     <= StIdle;
          end
        end

        default: begin
          r_state <= StCfgWait;
        end
      endcase
    end
  end

  assign write       = r_write;
  assign read        = r_read;
  assign address     = r_address;
  assign writedata   = r_writedata;
  assign coeff_ready = r_coeff_ready;
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_error   = r_out_error;
  assign cfg_done    = r_cfg_done;

endmodule

// File: tb/tb_neuron_bus_master.sv
// tb_neuron_bus_master
//   Directed bench for neuron_bus_master with a behavioural neuron slave.
//   Expected bus transactions and results are queued when stimulus is driven
//   and compared when the DUT issues them.
module tb_neuron_bus_master;

  localparam int unsigned Width = 32;
  localparam int unsigned PollT = 8;

  logic              CLK;
  logic              MasterReset;
  logic              coeff_valid;
  logic              coeff_ready;
  logic [Width-1:0]  coeff_data;
  logic              in_valid;
  logic              in_ready;
  logic [Width-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [Width-1:0]  out_data;
  logic              out_error;
  logic              cfg_done;
  logic              write;
  logic              read;
  logic [8:0]        address;
  logic [Width-1:0]  writedata;
  logic [Width-1:0]  readdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] data;
  } bus_t;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } out_t;

  bus_t bus_q[$];
  out_t out_q[$];

  // Slave model state
  int          listo_at;  // poll number that first reports Listo; 0 = never
  logic [31:0] res_val;
  logic        res_err;
  int          poll_n;

  neuron_bus_master #(
    .Width       (Width),
    .NumCoeff    (20),
    .PollTimeout (PollT)
  ) dut (
    .CLK         (CLK),
    .MasterReset (MasterReset),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .coeff_data  (coeff_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_error   (out_error),
    .cfg_done    (cfg_done),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input logic [8:0] a, input logic [31:0] d);
    bus_q.push_back({1'b1, a, d});
  endtask

  task automatic exp_rd(input logic [8:0] a);
    bus_q.push_back({1'b0, a, 32'h0});
  endtask

  // Slave: status reads count up from the Start write
  always @(posedge CLK) begin
    if (write && address == 9'd22) poll_n <= 0;
    else if (read && address == 9'd24) poll_n <= poll_n + 1;
  end

  always_comb begin
    readdata = '0;
    if (read && address == 9'd24) begin
      if (listo_at != 0 && (poll_n + 1) >= listo_at) readdata = {30'b0, res_err, 1'b1};
    end else if (read && address == 9'd23) begin
      readdata = res_val;
    end
  end

  // Bus scoreboard
  always @(negedge CLK) begin
    if (write || read) begin
      bus_t exp_op;
      exp_op = (bus_q.size() != 0) ? bus_q.pop_front() : '1;
      chk("bus_excl", {63'b0, write & read}, 64'd0);
      chk("bus_op", {22'b0, write, address, writedata}, {22'b0, exp_op});
    end
  end

  task automatic send_coeff(input logic [31:0] d);
    int n;
    coeff_valid = 1'b1;
    coeff_data  = d;
    n = 0;
    while (!coeff_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("coeff_ready_wait", {63'b0, coeff_ready}, 64'd1);
    @(negedge CLK);
    coeff_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [31:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("in_ready_wait", {63'b0, in_ready}, 64'd1);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic load_coeffs(input logic [31:0] base);
    for (int i = 0; i <= 20; i++) exp_wr(9'(i), base + (32'(i + 1) << 24));
    for (int i = 0; i <= 20; i++) send_coeff(base + (32'(i + 1) << 24));
  endtask

  // Queue the bus sequence and result of one evaluation, then send the sample.
  task automatic run_sample(input logic [31:0] d, input int lat, input logic [31:0] rv,
                            input logic re, input int npoll, input logic has_res,
                            input logic [31:0] exp_d, input logic exp_e);
    listo_at = lat;
    res_val  = rv;
    res_err  = re;
    exp_wr(9'd21, d);
    exp_wr(9'd22, 32'd1);
    for (int i = 0; i < npoll; i++) exp_rd(9'd24);
    if (has_res) exp_rd(9'd23);
    out_q.push_back({exp_d, exp_e});
    send_sample(d);
  endtask

  task automatic wait_out(input string tag, input int hold);
    int   n;
    out_t e;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
    e = (out_q.size() != 0) ? out_q.pop_front() : '1;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk({tag, "_hold_valid"}, {63'b0, out_valid}, 64'd1);
      chk({tag, "_hold_data"}, {32'b0, out_data}, {32'b0, e.d});
      chk({tag, "_hold_in_ready"}, {63'b0, in_ready}, 64'd0);
    end
    chk({tag, "_data"}, {32'b0, out_data}, {32'b0, e.d});
    chk({tag, "_error"}, {63'b0, out_error}, {63'b0, e.e});
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, {63'b0, out_valid}, 64'd0);
    chk({tag, "_idle_in_ready"}, {63'b0, in_ready}, 64'd1);
    chk({tag, "_bus_drain"}, 64'(bus_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    int cnt;
    MasterReset = 1'b1;
    coeff_valid = 1'b0;
    coeff_data  = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    listo_at    = 0;
    res_val     = '0;
    res_err     = 1'b0;
    repeat (3) @(negedge CLK);

    chk("rst_write", {63'b0, write}, 64'd0);
    chk("rst_read", {63'b0, read}, 64'd0);
    chk("rst_address", {55'b0, address}, 64'd0);
    chk("rst_writedata", {32'b0, writedata}, 64'd0);
    chk("rst_coeff_ready", {63'b0, coeff_ready}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_data", {32'b0, out_data}, 64'd0);
    chk("rst_out_error", {63'b0, out_error}, 64'd0);
    chk("rst_cfg_done", {63'b0, cfg_done}, 64'd0);
    MasterReset = 1'b0;

    // Coefficient load 0x01000000..0x15000000
    load_coeffs(32'h0);
    chk("cfg_done_last_wr", {63'b0, cfg_done}, 64'd0);
    @(negedge CLK);
    chk("cfg_done_set", {63'b0, cfg_done}, 64'd1);
    chk("cfg_in_ready", {63'b0, in_ready}, 64'd1);
    chk("cfg_bus_drain", 64'(bus_q.size()), 64'd0);

    // Listo on third poll
    run_sample(32'h0080_0000, 3, 32'h00C0_0000, 1'b0, 3, 1'b1, 32'h00C0_0000, 1'b0);
    wait_out("nominal", 0);

    // Status 0x3 on first poll
    run_sample(32'h0100_0000, 1, 32'h1234_5678, 1'b1, 1, 1'b1, 32'h1234_5678, 1'b1);
    wait_out("slave_err", 0);

    // Listo never set: timeout after PollT polls
    run_sample(32'hFF00_0000, 0, 32'hDEAD_BEEF, 1'b0, PollT, 1'b0, 32'h0, 1'b1);
    wait_out("timeout", 0);

    // Consumer stalls for 5 cycles
    run_sample(32'h0040_0000, 2, 32'h0ABC_DEF0, 1'b0, 2, 1'b1, 32'h0ABC_DEF0, 1'b0);
    wait_out("stall", 5);

    // Reload from IDLE while a sample is also offered: coefficients first
    in_valid = 1'b1;
    in_data  = 32'h0020_0000;
    load_coeffs(32'h0000_0100);
    run_sample(32'h0020_0000, 1, 32'h0000_0042, 1'b0, 1, 1'b1, 32'h0000_0042, 1'b0);
    wait_out("reload_prio", 0);

    // Reset during POLL
    listo_at = 0;
    exp_wr(9'd21, 32'h0300_0000);
    exp_wr(9'd22, 32'd1);
    exp_rd(9'd24);
    send_sample(32'h0300_0000);
    n = 0;
    while (!read && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("poll_reached", {63'b0, read}, 64'd1);
    MasterReset = 1'b1;
    @(negedge CLK);
    chk("midrst_read", {63'b0, read}, 64'd0);
    chk("midrst_write", {63'b0, write}, 64'd0);
    chk("midrst_cfg_done", {63'b0, cfg_done}, 64'd0);
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    MasterReset = 1'b0;
    chk("midrst_bus_drain", 64'(bus_q.size()), 64'd0);
    in_valid = 1'b1;
    in_data  = 32'h0500_0000;
    cnt = 0;
    repeat (10) begin
      @(negedge CLK);
      cnt += int'(in_ready);
    end
    chk("midrst_no_accept", 64'(cnt), 64'd0);
    in_valid = 1'b0;

    load_coeffs(32'h0000_0200);
    run_sample(32'h0500_0000, 2, 32'h7FFF_FFFF, 1'b0, 2, 1'b1, 32'h7FFF_FFFF, 1'b0);
    wait_out("after_reload", 0);

    repeat (3) @(negedge CLK);
    chk("final_bus_drain", 64'(bus_q.size()), 64'd0);
    chk("final_out_drain", 64'(out_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
